// File: rtl/cpu_types_pkg.sv
// ============================================================================
// cpu_types_pkg : shared pipeline types (stage-buffer FSM states, stage payloads)
// Revision      : 1.0
// ============================================================================
`default_nettype none

package cpu_types_pkg;

  localparam int XLEN   = 32;
  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_FULL  = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   rs1_val;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   imm;
    logic [REG_AW-1:0] rd;
    logic [3:0]        alu_op;
    logic              reg_we;
    logic              mem_re;
    logic              mem_we;
  } idex_t;

  typedef struct packed {
    logic [XLEN-1:0]   alu_result;
    logic [XLEN-1:0]   store_data;
    logic [REG_AW-1:0] rd;
    logic              reg_we;
    logic              mem_re;
    logic              mem_we;
  } exmem_t;

  typedef struct packed {
    logic [XLEN-1:0]   wb_data;
    logic [REG_AW-1:0] rd;
    logic              reg_we;
  } memwb_t;

  // Entries held by a two-entry stage in a given state.
  function automatic logic [1:0] state_occupancy(input pipe_state_t s);
    logic [1:0] occ;
    occ = 2'd0;
    case (s)
      PS_ONE:  occ = 2'd1;
      PS_FULL: occ = 2'd2;
      default: occ = 2'd0;
    endcase
    return occ;
  endfunction

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter : up-counter that sticks at all-ones, synchronous clear
// Revision    : 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge CLK) begin
    if (clear) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/pipe_stage_buf.sv
// ============================================================================
// pipe_stage_buf : valid/ready pipeline register with flush, optional skid
//                  entry and saturating back-pressure counter
// Revision       : 1.0
// ============================================================================
`default_nettype none

module pipe_stage_buf
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SKID  = 1,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             w_in_ready;
  logic             w_out_valid;
  logic [WIDTH-1:0] w_out_data;
  logic [1:0]       w_occupancy;
  logic             w_in_fire;
  logic             w_out_fire;

  assign w_in_fire  = in_valid & w_in_ready;
  assign w_out_fire = w_out_valid & out_ready;

  if (SKID != 0) begin : g_skid
    pipe_state_t      r_state;
    pipe_state_t      w_state_next;
    logic [WIDTH-1:0] r_main;
    logic [WIDTH-1:0] r_skid;
    logic [WIDTH-1:0] w_main_next;
    logic [WIDTH-1:0] w_skid_next;
    logic             r_in_ready;

    always_ff @(posedge CLK) begin
      if (RST) begin
        r_state    <= PS_EMPTY;
        r_main     <= '0;
        r_skid     <= '0;
        r_in_ready <= 1'b1;
      end else begin
        r_state    <= w_state_next;
        r_main     <= w_main_next;
        r_skid     <= w_skid_next;
        // Registered copy of (state != FULL) keeps out_ready off the in_ready path.
        r_in_ready <= (w_state_next != PS_FULL);
      end
    end

    always_comb begin
      w_state_next = r_state;
      w_main_next  = r_main;
      w_skid_next  = r_skid;
      if (flush) begin
        w_state_next = PS_EMPTY;
        w_main_next  = '0;
        w_skid_next  = '0;
      end else begin
        case (r_state)
          PS_EMPTY: begin
            if (w_in_fire) begin
              w_state_next = PS_ONE;
              w_main_next  = in_data;
            end
          end
          PS_ONE: begin
            if (w_in_fire && w_out_fire) begin
              w_main_next = in_data;
            end else if (w_in_fire) begin
              w_state_next = PS_FULL;
              w_skid_next  = in_data;
            end else if (w_out_fire) begin
              w_state_next = PS_EMPTY;
              w_main_next  = '0;
            end
          end
          PS_FULL: begin
            if (w_out_fire) begin
              w_state_next = PS_ONE;
              w_main_next  = r_skid;
              w_skid_next  = '0;
            end
          end
          default: begin
            w_state_next = PS_EMPTY;
            w_main_next  = '0;
            w_skid_next  = '0;
          end
        endcase
      end
    end

    assign w_in_ready  = r_in_ready;
    assign w_out_valid = (r_state != PS_EMPTY);
    assign w_out_data  = r_main;
    assign w_occupancy = state_occupancy(r_state);
  end else begin : g_single
    logic             r_valid;
    logic [WIDTH-1:0] r_main;

    always_ff @(posedge CLK) begin
      if (RST || flush) begin
        r_valid <= 1'b0;
        r_main  <= '0;
      end else if (w_in_fire) begin
        r_valid <= 1'b1;
        r_main  <= in_data;
      end else if (w_out_fire) begin
        r_valid <= 1'b0;
        r_main  <= '0;
      end
    end

    assign w_in_ready  = ~r_valid | out_ready;
    assign w_out_valid = r_valid;
    assign w_out_data  = r_main;
    assign w_occupancy = {1'b0, r_valid};
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .CLK   (CLK),
    .clear (RST),
    .inc   (w_out_valid & ~out_ready),
    .count (stall_cnt)
  );

  assign in_ready  = w_in_ready;
  assign out_valid = w_out_valid;
  assign out_data  = w_out_data;
  assign occupancy = w_occupancy;

endmodule

`default_nettype wire

// File: doc/pipe_stage_buf.md
Name: pipe_stage_buf

Overview:
- Generic, parametrised pipeline stage register that replaces the hand-written per-stage latch blocks between decode/execute/memory/writeback.
- Carries an opaque WIDTH-bit payload with a valid/ready handshake, synchronous flush (bubble insert) and an optional 2-entry skid buffer that registers the upstream ready path.
- Counts back-pressure cycles for performance debug.
- Sits between any two pipeline stages; the upstream stage packs its control/data fields into in_data.

Parameters:
- WIDTH, 32: payload width in bits (>=1).
- SKID, 1: 0 = single register, combinational in_ready; 1 = two entries, registered in_ready.
- CNT_W, 16: width of saturating stall counter.

Ports:
- CLK  in  1  clock, rising edge.
- RST  in  1  reset, synchronous, active-high.
- flush  in  1  discard all held entries this cycle.
- in_valid  in  1  upstream payload valid.
- in_ready  out  1  stage can accept this cycle.
- in_data  in  WIDTH  upstream payload.
- out_valid  out  1  head entry valid.
- out_ready  in  1  downstream accepts head.
- out_data  out  WIDTH  head payload; all zeros when out_valid=0.
- occupancy  out  2  entries held (0..1 if SKID=0, 0..2 if SKID=1).
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready, saturating.

Behaviour:
- Transfers: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Evaluated at the CLK edge.
- Reset (RST=1 at edge): all entries invalid, payload registers cleared to 0, occupancy=0, stall_cnt=0. Outputs after reset: out_valid=0, out_data=0, and in_ready=1.
- Flush (flush=1, RST=0):
  - All entries invalid and payloads zeroed next cycle.
  - A simultaneous in_fire is discarded.
  - stall_cnt is kept.
  - RST has priority over flush.
- Latency: 1 cycle. A payload accepted at edge N appears on out_data with out_valid=1 after edge N.
- Order: strict FIFO. No duplication or loss except on flush or reset.
- SKID=0:
  - in_ready = !out_valid | out_ready (combinational).
  - On in_fire the register loads in_data. Otherwise, on out_fire it becomes invalid and zeroed. Otherwise it holds.
- SKID=1, FSM with states EMPTY, ONE and FULL:
  - in_ready = (state != FULL), driven from a register only, with no combinational path from out_ready.
  - EMPTY: in_fire -> ONE (main <= in_data).
  - ONE:
    - in_fire & out_fire -> ONE (main <= in_data).
    - in_fire & !out_fire -> FULL (skid <= in_data).
    - out_fire & !in_fire -> EMPTY.
  - FULL: out_fire -> ONE (main <= skid, skid zeroed). No in_fire is possible in FULL.
  - Flush from any state -> EMPTY.
  - Head is always main; out_valid = (state != EMPTY).
- occupancy: 0/1/2 matching the state, or main-valid for SKID=0.
- stall_cnt:
  - Increments by 1 each edge where out_valid & !out_ready.
  - Saturates at 2^CNT_W-1 and never wraps.
  - Cleared only by RST.
- Invalid entries always hold zero payload, so a downstream stage that ignores out_valid sees an all-zero bubble. This is equivalent to a NOP, with no write enable and no memory access.
- No X propagation from in_data when in_valid=0: payload loads only on in_fire.

Decomposition:
- cpu_types_pkg gains a pipe_state_t enum (PS_EMPTY, PS_ONE, PS_FULL).
- cpu_types_pkg also gains per-stage packed structs (idex_t, exmem_t, memwb_t), whose $bits sets WIDTH at each instantiation.
- Natural sub-module: sat_counter (CNT_W parameter, inc, clear), used for stall_cnt and reusable elsewhere.
- The FSM and data path stay in pipe_stage_buf.

Test Plan:
1. Reset, then release: out_valid=0, out_data=0, in_ready=1, occupancy=0, stall_cnt=0. Assert RST mid-FULL: next cycle the same values are restored.
2. SKID=1, out_ready=1, in_valid=1 streaming 0x1..0x8 on consecutive cycles -> out_data 0x1..0x8 one cycle later each, occupancy stays 1, stall_cnt=0.
3. SKID=1, out_ready=0, push 0xA, 0xB, then offer 0xC -> occupancy=2, in_ready=0, and 0xC is not taken. Then raise out_ready -> 0xA, 0xB, 0xC emerge in order. stall_cnt equals the cycles held.
4. FULL (0xA, 0xB), then flush=1 with in_valid=1 carrying 0xD -> next cycle out_valid=0, out_data=0, occupancy=0, and 0xD is never output.
5. SKID=0, out_ready=0 with 0x5 held, in_valid=1 carrying 0x6 -> in_ready=0, 0x5 held. Raise out_ready -> same-cycle in_ready=1, then 0x6 follows 0x5.
6. CNT_W=4, hold out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt reaches 15 and stays at 15.
